capture_buffer_readout: RTL

- Dual-channel sample store directly downstream of the system controller.
- Captures the controller's addressed write stream (data, valid, address per channel) into two synchronous RAMs while the measurement runs.
- After the controller reports finish, firmware drains both buffers through a request/valid read port, one word per request.
- Sits between the system controller and the FW register/AXI bridge.

---
 rtl/capture_buffer_readout.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/capture_buffer_readout.sv
// capture_buffer_readout
//   Two-channel sample store. The controller's addressed write stream is captured into two
//   synchronous RAMs while the measurement runs. Once the controller sits in FINISH, firmware
//   drains both buffers one word per rd_req.
//
// Optional feature (compile-time macro RD_INTERLEAVE_EN):
//   undefined : readout order ch0[0..cnt0-1] then ch1[0..cnt1-1]
//   defined   : readout alternates ch0/ch1; the longer channel's tail follows in index order
//
// Ports:
//   clk, rstn                          single clock, asynchronous active-low reset
//   wr_data/wr_vld/wr_addr_ch0/ch1     controller write stream per channel
//   finish_op                          controller FINISH-state level
//   rd_start, rd_req                   firmware pulses: begin readout / request next word
//   rd_data, rd_vld, rd_ch, rd_idx     read word, 1-cycle valid pulse, its channel and index
//   rd_done                            level, high while every captured word has been delivered
//   cap_count_ch0/ch1                  words captured per channel (saturates at FIFO_SIZE)
//   event_wr_when_not_capturing        pulse: write strobe seen outside CAPTURE
//   event_rd_req_when_not_reading      pulse: rd_req seen outside READOUT
module capture_buffer_readout #(
  parameter int unsigned FIFO_SIZE  = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_SIZE),
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] wr_data_ch0,
  input  logic                  wr_vld_ch0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_ch0,
  input  logic [DATA_WIDTH-1:0] wr_data_ch1,
  input  logic                  wr_vld_ch1,
  input  logic [ADDR_WIDTH-1:0] wr_addr_ch1,
  input  logic                  finish_op,
  input  logic                  rd_start,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  output logic                  rd_ch,
  output logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_done,
  output logic [CNT_WIDTH-1:0]  cap_count_ch0,
  output logic [CNT_WIDTH-1:0]  cap_count_ch1,
  output logic                  event_wr_when_not_capturing,
  output logic                  event_rd_req_when_not_reading
);

  typedef enum logic [1:0] {StCapture, StReady, StReadout, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]   SumOne = {{CNT_WIDTH{1'b0}}, 1'b1};

  state_e r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem0 [FIFO_SIZE];
  logic [DATA_WIDTH-1:0] r_mem1 [FIFO_SIZE];
  logic [DATA_WIDTH-1:0] r_ram_q;

  logic [CNT_WIDTH-1:0]  r_cnt0, r_cnt1;
  logic [CNT_WIDTH-1:0]  r_len0, r_len1;   // counts frozen at readout start
  logic [CNT_WIDTH-1:0]  r_ptr0, r_ptr1;   // words issued per channel
  logic                  r_rd_vld;
  logic                  r_rd_ch;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic                  r_evt_wr;
  logic                  r_evt_rd;

  logic                  w_left0, w_left1;
  logic [CNT_WIDTH:0]    w_issued, w_total;
  logic                  w_any_left;
  logic                  w_sel_ch;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_issue;
  logic                  w_last;
  logic                  w_enter_cap;
  logic                  w_start_rd;
  logic                  w_cap;

  assign w_cap       = (r_state == StCapture);
  assign w_left0     = (r_ptr0 < r_len0);
  assign w_left1     = (r_ptr1 < r_len1);
  assign w_issued    = {1'b0, r_ptr0} + {1'b0, r_ptr1};
  assign w_total     = {1'b0, r_len0} + {1'b0, r_len1};
  assign w_any_left  = (w_issued != w_total);

`ifdef RD_INTERLEAVE_EN
  logic r_turn;  // channel preferred for the next issue while both still have words
  assign w_sel_ch = (w_left0 && w_left1) ? r_turn : !w_left0;
`else
  assign w_sel_ch = !w_left0;
`endif

  assign w_rd_addr   = w_sel_ch ? r_ptr1[ADDR_WIDTH-1:0] : r_ptr0[ADDR_WIDTH-1:0];
  // A request in the same cycle finish_op drops is discarded so no rd_vld follows an abort.
  assign w_issue     = (r_state == StReadout) && rd_req && finish_op && w_any_left;
  assign w_last      = w_issue && ((w_issued + SumOne) == w_total);
  assign w_enter_cap = (r_state != StCapture) && (w_state_nxt == StCapture);
  assign w_start_rd  = (r_state == StReady) && (w_state_nxt == StReadout);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StCapture: if (finish_op) w_state_nxt = StReady;
      StReady: begin
        if (!finish_op)    w_state_nxt = StCapture;
        else if (rd_start) w_state_nxt = StReadout;
      end
      StReadout: begin
        if (!finish_op)                 w_state_nxt = StCapture;
        else if (!w_any_left || w_last) w_state_nxt = StDone;
      end
      StDone: if (!finish_op) w_state_nxt = StCapture;
      default: w_state_nxt = StCapture;
    endcase
  end

  // Sample RAMs: no reset on the arrays or the read register.
  always_ff @(posedge clk) begin
    if (w_cap && wr_vld_ch0) r_mem0[wr_addr_ch0] <= wr_data_ch0;
    if (w_cap && wr_vld_ch1) r_mem1[wr_addr_ch1] <= wr_data_ch1;
    if (w_issue) r_ram_q <= w_sel_ch ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StCapture;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_len0   <= '0;
      r_len1   <= '0;
      r_ptr0   <= '0;
      r_ptr1   <= '0;
      r_rd_vld <= 1'b0;
      r_rd_ch  <= 1'b0;
      r_rd_idx <= '0;
      r_evt_wr <= 1'b0;
      r_evt_rd <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= w_issue;
      r_evt_wr <= !w_cap && (wr_vld_ch0 || wr_vld_ch1);
      r_evt_rd <= (r_state != StReadout) && rd_req;
      if (w_issue) begin
        r_rd_ch  <= w_sel_ch;
        r_rd_idx <= w_rd_addr;
      end

      if (w_enter_cap) begin
        r_cnt0 <= '0;
        r_cnt1 <= '0;
      end else if (w_cap) begin
        if (wr_vld_ch0 && (r_cnt0 != CntMax)) r_cnt0 <= r_cnt0 + CntOne;
        if (wr_vld_ch1 && (r_cnt1 != CntMax)) r_cnt1 <= r_cnt1 + CntOne;
      end

      if (w_enter_cap) begin
        r_ptr0 <= '0;
        r_ptr1 <= '0;
      end else if (w_start_rd) begin
        r_len0 <= r_cnt0;
        r_len1 <= r_cnt1;
        r_ptr0 <= '0;
        r_ptr1 <= '0;
      end else if (w_issue) begin
        if (w_sel_ch) r_ptr1 <= r_ptr1 + CntOne;
        else          r_ptr0 <= r_ptr0 + CntOne;
      end
    end
  end

`ifdef RD_INTERLEAVE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_turn <= 1'b0;
    end else if (w_start_rd || w_enter_cap) begin
      r_turn <= 1'b0;
    end else if (w_issue) begin
      r_turn <= !w_sel_ch;
    end
  end
`endif

  // Data is forced to zero outside the valid pulse so the unreset RAM register never leaks out.
  assign rd_data                       = r_ram_q & {DATA_WIDTH{r_rd_vld}};
  assign rd_vld                        = r_rd_vld;
  assign rd_ch                         = r_rd_ch;
  assign rd_idx                        = r_rd_idx;
  assign rd_done                       = (r_state == StDone);
  assign cap_count_ch0                 = r_cnt0;
  assign cap_count_ch1                 = r_cnt1;
  assign event_wr_when_not_capturing   = r_evt_wr;
  assign event_rd_req_when_not_reading = r_evt_rd;

endmodule
